// File: rtl/simon_seq_checker_if.sv
// Bundle between the Simon game controller (master) and the player-side
// sequence checker (slave), including the sequence-memory read port.
interface simon_seq_checker_if #(
  parameter int ADDR_W = 4
);
  // Signalling contract:
  //  - start is a single-cycle request. It is honoured only while the checker
  //    is idle and not in game over; otherwise it is dropped, with no back-pressure.
  //  - press_valid and round_ok are single-cycle pulses with no ready; the
  //    consumer must sample them every cycle.
  //  - game_over is a level that stays high until reset.
  //  - seq_data must reflect seq_addr in the same cycle (combinational read).
  logic              start;
  logic [ADDR_W-1:0] round_len;
  logic [ADDR_W-1:0] seq_addr;
  logic [1:0]        seq_data;
  logic [1:0]        btn_num;
  logic              btn_pressed;
  logic              active;
  logic [ADDR_W-1:0] step;
  logic              press_valid;
  logic              round_ok;
  logic              game_over;
  logic [2:0]        dbg_state;

  modport master (
    output start, round_len, seq_data, btn_num, btn_pressed,
    input  seq_addr, active, step, press_valid, round_ok, game_over, dbg_state
  );

  modport slave (
    input  start, round_len, seq_data, btn_num, btn_pressed,
    output seq_addr, active, step, press_valid, round_ok, game_over, dbg_state
  );
endinterface

// File: rtl/simon_seq_checker.sv
// Player-side Simon checker: debounces the button level, matches each press
// against the stored sequence, and reports round success or game over.
module simon_seq_checker #(
  parameter int MAX_LEN         = 10,
  parameter int ADDR_W          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic                clk,
  input  logic                reset,
  simon_seq_checker_if.slave  bus
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ARM          = 3'd1,
    S_WAIT_PRESS   = 3'd2,
    S_WAIT_RELEASE = 3'd3,
    S_FAIL         = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              press_d, ok_d;
  logic              press_valid_q, round_ok_q, game_over_q;
  logic              deb_level;
  logic [DEB_W-1:0]  deb_cnt;

  logic [ADDR_W-1:0] len_clamped;
  logic [ADDR_W-1:0] step_inc;
  logic              tmo_expired;

  // The debounced level only moves after the raw level has disagreed with it
  // for DEBOUNCE_CYCLES consecutive samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else if (bus.btn_pressed != deb_level) begin
      if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_level <= bus.btn_pressed;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  assign len_clamped = (bus.round_len > ADDR_W'(MAX_LEN)) ? ADDR_W'(MAX_LEN) : bus.round_len;
  assign step_inc    = step_q + ADDR_W'(1);
  assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // WAIT_PRESS is only entered with deb_level low, so a high level there is
  // exactly the press edge; likewise a low level in WAIT_RELEASE is the release edge.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    press_d = 1'b0;
    ok_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !game_over_q) begin
          len_d  = len_clamped;
          step_d = '0;
          tmo_d  = '0;
          if (len_clamped == '0) ok_d = 1'b1;
          else                   state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (tmo_expired) begin
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (!deb_level) state_d = S_WAIT_PRESS;
        end
      end
      S_WAIT_PRESS: begin
        if (tmo_expired) begin
          state_d = S_FAIL;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
          if (deb_level) begin
            if (bus.btn_num == bus.seq_data) begin
              press_d = 1'b1;
              state_d = S_WAIT_RELEASE;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
      end
      S_WAIT_RELEASE: begin
        if (!deb_level) begin
          tmo_d = '0;
          if (step_inc == len_q) begin
            ok_d    = 1'b1;
            step_d  = '0;
            state_d = S_IDLE;
          end else begin
            step_d  = step_inc;
            state_d = S_WAIT_PRESS;
          end
        end
      end
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      step_q        <= '0;
      len_q         <= '0;
      tmo_q         <= '0;
      press_valid_q <= 1'b0;
      round_ok_q    <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      len_q         <= len_d;
      tmo_q         <= tmo_d;
      press_valid_q <= press_d;
      round_ok_q    <= ok_d;
      game_over_q   <= game_over_q | (state_d == S_FAIL);
    end
  end

  assign bus.seq_addr    = step_q;
  assign bus.step        = step_q;
  assign bus.active      = (state_q == S_ARM) || (state_q == S_WAIT_PRESS) ||
                           (state_q == S_WAIT_RELEASE);
  assign bus.press_valid = press_valid_q;
  assign bus.round_ok    = round_ok_q;
  assign bus.game_over   = game_over_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_simon_seq_checker.sv
// Bench for simon_seq_checker: random and directed rounds scored against a
// game-level model of what the player's presses should produce.
module tb_simon_seq_checker;

  localparam int ADDR_W  = 4;
  localparam int MAX_LEN = 10;
  localparam int DEB     = 4;
  localparam int TMO     = 100;

  localparam logic [1:0] EV_PRESS = 2'd1;
  localparam logic [1:0] EV_OK    = 2'd2;
  localparam logic [1:0] EV_OVER  = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  simon_seq_checker_if #(.ADDR_W(ADDR_W)) bus ();

  logic [1:0] mem [16];
  assign bus.seq_data = mem[bus.seq_addr];

  simon_seq_checker #(
    .MAX_LEN(MAX_LEN),
    .ADDR_W(ADDR_W),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [1:0] cols[$];
  logic go_prev = 1'b0;

  function automatic logic [7:0] ev(input logic [1:0] kind, input logic [3:0] idx);
    return {kind, 2'b00, idx};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic observe(input logic [7:0] got);
    logic [7:0] want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_unexpected actual=%h required=none", got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL scoreboard_event actual=%h required=%h", got, want);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      go_prev <= 1'b0;
    end else begin
      if (bus.press_valid)             observe(ev(EV_PRESS, bus.step));
      if (bus.round_ok)                observe(ev(EV_OK, 4'd0));
      if (bus.game_over && !go_prev)   observe(ev(EV_OVER, 4'd0));
      go_prev <= bus.game_over;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.btn_pressed = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic start_round(input int len_req);
    @(negedge clk);
    bus.round_len = ADDR_W'(len_req);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  // Holds a colour for `hold` cycles then releases for `gap` cycles; with
  // wiggle set, btn_num is scrambled once the press edge is well past.
  task automatic press(input logic [1:0] colour, input int hold, input int gap, input bit wiggle);
    bus.btn_num     = colour;
    bus.btn_pressed = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (wiggle && i >= 6) bus.btn_num = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    bus.btn_pressed = 1'b0;
    tick(gap);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 80) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // ---------------- reference model + round player ----------------
  // Game rules: the round length is capped at MAX_LEN; each press either
  // matches mem[i] (scored press at index i, round_ok after the last one) or
  // ends the game.
  task automatic play(input int len_req, input int gmin, input int gmax, input bit check_step);
    int len;
    int n;
    len = (len_req > MAX_LEN) ? MAX_LEN : len_req;
    n = 0;
    if (len == 0) exp_q.push_back(ev(EV_OK, 4'd0));
    for (int i = 0; i < cols.size() && i < len; i++) begin
      n++;
      if (cols[i] == mem[i]) begin
        exp_q.push_back(ev(EV_PRESS, 4'(i)));
        if (i + 1 == len) exp_q.push_back(ev(EV_OK, 4'd0));
      end else begin
        exp_q.push_back(ev(EV_OVER, 4'd0));
        break;
      end
    end
    start_round(len_req);
    for (int i = 0; i < n; i++) begin
      press(cols[i], $urandom_range(6, 12), $urandom_range(gmin, gmax), 1'b1);
      if (check_step && cols[i] == mem[i])
        check("step_after_release", bus.step, (i + 1 == len) ? 0 : i + 1);
    end
    drain();
  endtask

  task automatic load_mem_random();
    for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
  endtask

  task automatic cols_from_mem(input int n);
    cols.delete();
    for (int i = 0; i < n; i++) cols.push_back(mem[i]);
  endtask

  task automatic load_mem_203();
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    mem[0] = 2'd2;
    mem[1] = 2'd0;
    mem[2] = 2'd3;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int len;
    int k;
    bus.start       = 1'b0;
    bus.round_len   = '0;
    bus.btn_num     = 2'd0;
    bus.btn_pressed = 1'b0;
    load_mem_203();
    tick(3);
    #1;
    check("reset_step",        bus.step,        0);
    check("reset_seq_addr",    bus.seq_addr,    0);
    check("reset_active",      bus.active,      0);
    check("reset_press_valid", bus.press_valid, 0);
    check("reset_round_ok",    bus.round_ok,    0);
    check("reset_game_over",   bus.game_over,   0);
    reset = 1'b0;
    tick(2);

    // Directed full round 2,0,3 with 10-cycle holds.
    cols_from_mem(3);
    play(3, 8, 10, 1'b1);
    check("t1_active_idle", bus.active,    0);
    check("t1_game_over",   bus.game_over, 0);

    // Random correct rounds.
    for (int r = 0; r < 6; r++) begin
      load_mem_random();
      len = $urandom_range(1, MAX_LEN);
      cols_from_mem(len);
      play(len, 6, 20, 1'b1);
    end

    // Length clamp and zero-length round.
    load_mem_random();
    cols_from_mem(MAX_LEN);
    play(15, 6, 10, 1'b1);
    cols.delete();
    play(0, 6, 6, 1'b0);
    check("len0_active", bus.active, 0);

    // Button held across start: must be released and pressed afresh.
    load_mem_203();
    exp_q.push_back(ev(EV_PRESS, 4'd0));
    exp_q.push_back(ev(EV_PRESS, 4'd1));
    exp_q.push_back(ev(EV_PRESS, 4'd2));
    exp_q.push_back(ev(EV_OK, 4'd0));
    bus.btn_num     = 2'd2;
    bus.btn_pressed = 1'b1;
    tick(6);
    start_round(3);
    tick(10);
    check("held_active", bus.active, 1);
    check("held_step",   bus.step,   0);
    bus.btn_pressed = 1'b0;
    tick(6);
    press(2'd2, 8, 8, 1'b1);
    press(2'd0, 8, 8, 1'b1);
    press(2'd3, 8, 8, 1'b1);
    drain();

    // Glitch shorter than the debounce window is not a press; exactly DEB is.
    exp_q.push_back(ev(EV_PRESS, 4'd0));
    start_round(3);
    press(2'd2, 3, 8, 1'b0);
    check("glitch_step",   bus.step,   0);
    check("glitch_active", bus.active, 1);
    press(2'd2, 4, 8, 1'b0);
    check("deb4_step", bus.step, 1);
    drain();
    do_reset();

    // Timeout: no press at all after start.
    exp_q.push_back(ev(EV_OVER, 4'd0));
    start_round(3);
    cyc = 0;
    while (!bus.game_over && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("timeout_cycle", cyc, TMO);
    drain();
    do_reset();

    // Long gaps under the timeout after accepted releases.
    cols_from_mem(3);
    play(3, 90, 90, 1'b0);
    check("long_gap_game_over", bus.game_over, 0);

    // Mismatch on second press; later start and presses are ignored.
    cols.delete();
    cols.push_back(2'd2);
    cols.push_back(2'd1);
    play(3, 8, 8, 1'b0);
    check("mismatch_game_over", bus.game_over, 1);
    start_round(3);
    tick(6);
    press(2'd2, 8, 8, 1'b0);
    check("fail_start_ignored", bus.active,    0);
    check("fail_sticky",        bus.game_over, 1);
    drain();

    // Reset in the middle of a round.
    do_reset();
    exp_q.push_back(ev(EV_PRESS, 4'd0));
    exp_q.push_back(ev(EV_PRESS, 4'd1));
    start_round(3);
    press(2'd2, 8, 8, 1'b1);
    press(2'd0, 8, 8, 1'b1);
    drain();
    check("mid_step", bus.step, 2);
    reset = 1'b1;
    #1;
    check("midrst_step",      bus.step,      0);
    check("midrst_seq_addr",  bus.seq_addr,  0);
    check("midrst_active",    bus.active,    0);
    check("midrst_game_over", bus.game_over, 0);
    tick(2);
    reset = 1'b0;
    tick(1);
    cols_from_mem(3);
    play(3, 6, 12, 1'b1);

    // Random mismatch round.
    load_mem_random();
    len = $urandom_range(2, MAX_LEN);
    cols_from_mem(len);
    k = $urandom_range(0, len - 1);
    cols[k] = cols[k] ^ 2'($urandom_range(1, 3));
    play(len, 6, 15, 1'b0);
    check("rand_mismatch_game_over", bus.game_over, 1);

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
